// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: types and constants shared by the fetch stage.
//   word_t        : 32-bit instruction / address word
//   PC_INCR       : sequential PC step
//   fetch_state_t : fetch FSM states
//   ifid_t        : IF/ID latch contents
//   align_word()  : clears the two low address bits
package cpu_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DROP   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic  valid;
        word_t instr;
        word_t pc;
        word_t npc;
    } ifid_t;

    function automatic word_t align_word(input word_t a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: single-entry buffer for an instruction that arrived from
// the icache while decode was stalled.
// Ports:
//   CLK, nRST         clock, async active-low reset
//   load              capture load_instr/load_pc, mark full
//   drain             consumer took the entry, mark empty
//   clr               discard the entry (redirect / halt); wins over load
//   load_instr/pc     data to capture
//   valid, instr, pc  buffer contents
module fetch_hold_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  drain,
    input  logic  clr,
    input  word_t load_instr,
    input  word_t load_pc,
    output logic  valid,
    output word_t instr,
    output word_t pc
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clr) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for one pipeline core. Owns the PC, talks
// to the icache and fills the IF/ID latch.
// Ports:
//   CLK, nRST      clock, async active-low reset
//   ihit, iload    icache response and instruction word
//   iREN, iaddr    icache read request and address (iaddr == pc)
//   stall          ID cannot accept; IF/ID latch holds
//   redirect       taken branch / JAL / JALR; redirect_pc is the target
//   halt           HALT decoded in ID
//   ifid_*         IF/ID latch: valid, instr, pc, npc (= pc + 4)
//   dbg_state      current fetch FSM state
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt
// (saturating, frozen once halted).
//
// Icache handshake: iREN is the request valid, ihit is the response.
// While iREN=1, iaddr stays constant until the cycle ihit=1; the word on
// iload is only meaningful in that cycle. A request in flight can never
// be cancelled, only its data discarded (DROP, and HALTED with halt_wait).
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_npc,
    output fetch_state_t      dbg_state
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    fetch_state_t state, state_n;
    word_t        pc, pc_n;
    word_t        drop_target, drop_target_n;
    logic         halt_wait, halt_wait_n;
    ifid_t        ifid, ifid_n;

    logic         hold_load, hold_drain, hold_clr;
    logic         hold_valid;
    word_t        hold_instr, hold_pc;
    word_t        target;

    assign target = align_word(redirect_pc);

    // HALTED keeps requesting only while the request issued before the
    // halt is still waiting for its ihit.
    assign iREN = (state == FETCH) || (state == DROP) ||
                  ((state == HALTED) && halt_wait);

    fetch_hold_buf u_hold (
        .CLK        (CLK),
        .nRST       (nRST),
        .load       (hold_load),
        .drain      (hold_drain),
        .clr        (hold_clr),
        .load_instr (iload),
        .load_pc    (pc),
        .valid      (hold_valid),
        .instr      (hold_instr),
        .pc         (hold_pc)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= FETCH;
            pc          <= align_word(PC_INIT);
            drop_target <= '0;
            halt_wait   <= 1'b0;
            ifid        <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop_target <= drop_target_n;
            halt_wait   <= halt_wait_n;
            ifid        <= ifid_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        drop_target_n = drop_target;
        halt_wait_n   = halt_wait;
        ifid_n        = ifid;
        hold_load     = 1'b0;
        hold_drain    = 1'b0;
        hold_clr      = 1'b0;

        if (state == HALTED) begin
            // Only the leftover request can complete; its data is dropped.
            if (ihit) halt_wait_n = 1'b0;
        end else if (redirect) begin
            ifid_n.valid = 1'b0;
            hold_clr     = 1'b1;
            if (iREN && !ihit) begin
                // Old request still in flight: wait it out in DROP.
                state_n       = DROP;
                drop_target_n = target;
            end else begin
                pc_n    = target;
                state_n = FETCH;
            end
        end else if (halt) begin
            ifid_n.valid = 1'b0;
            hold_clr     = 1'b1;
            state_n      = HALTED;
            halt_wait_n  = iREN && !ihit;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        if (stall) begin
                            hold_load = 1'b1;
                            pc_n      = pc + PC_INCR;
                            state_n   = HOLD;
                        end else begin
                            ifid_n.valid = 1'b1;
                            ifid_n.instr = iload;
                            ifid_n.pc    = pc;
                            ifid_n.npc   = pc + PC_INCR;
                            pc_n         = pc + PC_INCR;
                        end
                    end else if (!stall) begin
                        ifid_n.valid = 1'b0;
                    end
                end
                DROP: begin
                    if (ihit) begin
                        pc_n    = drop_target;
                        state_n = FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_n.valid = hold_valid;
                        ifid_n.instr = hold_instr;
                        ifid_n.pc    = hold_pc;
                        ifid_n.npc   = hold_pc + PC_INCR;
                        hold_drain   = 1'b1;
                        state_n      = FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign iaddr      = pc;
    assign ifid_valid = ifid.valid;
    assign ifid_instr = ifid.instr;
    assign ifid_pc    = ifid.pc;
    assign ifid_npc   = ifid.npc;
    assign dbg_state  = state;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;

    // A live instruction enters IF/ID from the icache or from the hold buffer.
    assign fetch_inc = !redirect && !halt && !stall &&
                       (((state == FETCH) && ihit) || (state == HOLD));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (state != HALTED) begin
            if (fetch_inc && (fetch_cnt != '1))
                fetch_cnt <= fetch_cnt + 32'd1;
            if (iREN && !ihit && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import cpu_types_pkg::*;

    localparam int W = 96;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_npc;
    fetch_state_t dbg_state;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic stall_q = 1'b0;

    fetch_stage #(
        .PC_INIT (32'h0000_0200),
        .WORD_W  (32)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .iload       (iload),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .ifid_valid  (ifid_valid),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_npc    (ifid_npc),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // stall seen by the DUT at the last rising edge
    always @(posedge CLK) stall_q <= stall;

    // ---------------- scoreboard monitor ----------------
    // A new instruction has entered IF/ID whenever the latch is valid after
    // an edge at which ID was not stalled.
    always @(negedge CLK) begin
        logic [W-1:0] exp_v;
        if (nRST && !stall_q && ifid_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL ifid_unexpected: got pc=%h instr=%h, required no instruction",
                         ifid_pc, ifid_instr);
            end else begin
                exp_v = exp_q.pop_front();
                if ({ifid_instr, ifid_pc, ifid_npc} !== exp_v) begin
                    n_err++;
                    $display("FAIL ifid_entry: got instr=%h pc=%h npc=%h, required instr=%h pc=%h npc=%h",
                             ifid_instr, ifid_pc, ifid_npc,
                             exp_v[95:64], exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Apply one cycle of inputs; returns 1 time unit after the rising edge.
    task automatic step(input logic ih, input logic [31:0] ld, input logic st,
                        input logic rd, input logic [31:0] rpc, input logic hl);
        ihit        = ih;
        iload       = ld;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        halt        = hl;
        @(posedge CLK);
        #1;
    endtask

    // Fetch one word with no stall and record the expected IF/ID entry.
    task automatic fetch_ok(input logic [31:0] ld, input logic [31:0] at_pc);
        exp_q.push_back({ld, at_pc, at_pc + 32'd4});
        step(1'b1, ld, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        nRST = 1'b0;
        ihit = 1'b0; iload = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

        // Reset values
        #12;
        chk("rst_iaddr",      iaddr,      32'h200);
        chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        chk("rst_ifid_pc",    ifid_pc,    32'h0);
        chk("rst_ifid_npc",   ifid_npc,   32'h0);
        nRST = 1'b1;
        #1;
        chk("rst_iren",  {31'b0, iREN}, 32'h1);
        chk("rst_state", 32'(dbg_state), 32'(FETCH));

        // Back-to-back hits from PC_INIT
        fetch_ok(32'h0050_0093, 32'h200);
        fetch_ok(32'h0050_0093, 32'h204);
        fetch_ok(32'h0050_0093, 32'h208);
        chk("seq_iaddr", iaddr, 32'h20C);
        chk("seq_iren",  {31'b0, iREN}, 32'h1);
        idle();
        chk("bubble_valid", {31'b0, ifid_valid}, 32'h0);

        // Stall with hold buffer at pc 0x10
        step(1'b1, 32'hBAD0_0001, 1'b0, 1'b1, 32'h0000_000C, 1'b0);
        chk("redir_hit_iaddr", iaddr, 32'h0C);
        chk("redir_hit_valid", {31'b0, ifid_valid}, 32'h0);
        fetch_ok(32'h00C0_0013, 32'h0C);
        step(1'b1, 32'h00A0_0113, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_state", 32'(dbg_state), 32'(HOLD));
            chk("hold_iren",  {31'b0, iREN}, 32'h0);
            chk("hold_iaddr", iaddr, 32'h14);
            chk("hold_ifid_pc",    ifid_pc,    32'h0C);
            chk("hold_ifid_instr", ifid_instr, 32'h00C0_0013);
            chk("hold_ifid_valid", {31'b0, ifid_valid}, 32'h1);
            if (i < 2) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        exp_q.push_back({32'h00A0_0113, 32'h10, 32'h14});
        idle();
        chk("drain_state", 32'(dbg_state), 32'(FETCH));
        chk("drain_iaddr", iaddr, 32'h14);
        chk("drain_iren",  {31'b0, iREN}, 32'h1);

        // Redirect while a request is outstanding at 0x20
        step(1'b1, 32'hBAD0_0002, 1'b0, 1'b1, 32'h20, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h70, 1'b0);
        chk("drop_state", 32'(dbg_state), 32'(DROP));
        chk("drop_iaddr", iaddr, 32'h20);
        chk("drop_iren",  {31'b0, iREN}, 32'h1);
        // second redirect overwrites the target; low bits ignored
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h83, 1'b0);
        chk("drop2_iaddr", iaddr, 32'h20);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drop_done_valid", {31'b0, ifid_valid}, 32'h0);
        chk("drop_done_iaddr", iaddr, 32'h80);
        chk("drop_done_state", 32'(dbg_state), 32'(FETCH));
        fetch_ok(32'h0080_0093, 32'h80);

        // Redirect and halt in the same cycle: redirect wins
        step(1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 32'h30, 1'b1);
        chk("rh_iaddr", iaddr, 32'h30);
        chk("rh_state", 32'(dbg_state), 32'(FETCH));
        chk("rh_iren",  {31'b0, iREN}, 32'h1);
        chk("rh_valid", {31'b0, ifid_valid}, 32'h0);

        // HALT decoded with ifid_pc 0x3C, request at 0x40 outstanding
        fetch_ok(32'h0300_0013, 32'h30);
        fetch_ok(32'h0340_0013, 32'h34);
        fetch_ok(32'h0380_0013, 32'h38);
        fetch_ok(32'hFFFF_FFFF, 32'h3C);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("halt_state",   32'(dbg_state), 32'(HALTED));
        chk("halt_valid",   {31'b0, ifid_valid}, 32'h0);
        chk("halt_ifid_pc", ifid_pc, 32'h3C);
        chk("halt_iren_pending", {31'b0, iREN}, 32'h1);
        idle();
        chk("halt_iren_wait", {31'b0, iREN}, 32'h1);
        step(1'b1, 32'hBAD0_0004, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_late_valid", {31'b0, ifid_valid}, 32'h0);
        for (int i = 0; i < 20; i++) begin
            chk("halted_iren",    {31'b0, iREN}, 32'h0);
            chk("halted_iaddr",   iaddr, 32'h40);
            chk("halted_ifid_pc", ifid_pc, 32'h3C);
            idle();
        end

        // Reset pulse leaves HALTED
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        #1;
        chk("rst2_state", 32'(dbg_state), 32'(FETCH));
        chk("rst2_iaddr", iaddr, 32'h200);

        // Reset in the middle of a request at 0x40
        step(1'b1, 32'hBAD0_0005, 1'b0, 1'b1, 32'h3C, 1'b0);
        fetch_ok(32'h03C0_0013, 32'h3C);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("mid_iaddr", iaddr, 32'h40);
        chk("mid_valid", {31'b0, ifid_valid}, 32'h1);
        stall = 1'b0;
        #1;
        nRST = 1'b0;
        #1;
        chk("mid_rst_iaddr", iaddr, 32'h200);
        chk("mid_rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("mid_rst_pc",    ifid_pc, 32'h0);
        step(1'b1, 32'hBAD0_0006, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("late_hit_valid", {31'b0, ifid_valid}, 32'h0);
        chk("late_hit_iaddr", iaddr, 32'h200);
        ihit = 1'b0;
        nRST = 1'b1;
        #1;
        chk("post_rst_iren", {31'b0, iREN}, 32'h1);
        fetch_ok(32'h0000_0013, 32'h200);
        chk("post_rst_iaddr", iaddr, 32'h204);

        // wrap of the sequential PC
        step(1'b1, 32'hBAD0_0007, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        fetch_ok(32'h0FF0_0013, 32'hFFFF_FFFC);
        chk("wrap_iaddr", iaddr, 32'h0);

        idle();
        idle();
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
